reorder_buffer: RTL and testbench

16-entry circular reorder buffer for the LC-3b Tomasulo core. It sits directly downstream of instruction fetch/issue, which allocates one entry per issued instruction, and downstream of the common data bus (ALUs and load modules), which delivers results. It retires entries strictly in program order to the register file, the condition codes and data memory, and answers operand-readiness lookups for dispatch into the reservation stations.

---
 rtl/reorder_buffer.sv | 227 ++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular reorder buffer for the LC-3b Tomasulo core.
// Entries complete out of order from the CDB and retire from the head strictly in program order.
module reorder_buffer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        alloc_valid,
  output logic        alloc_ready,
  output logic [3:0]  alloc_id,
  input  logic [3:0]  alloc_opcode,
  input  logic [2:0]  alloc_dest_reg,
  input  logic [15:0] alloc_address,
  input  logic [15:0] alloc_value,
  input  logic        alloc_done,
  input  logic        alloc_modifies_cc,
  input  logic        alloc_writes_reg,
  input  logic        alloc_writes_mem,
  input  logic        cdb_valid,
  input  logic [23:0] cdb_data,
  input  logic [3:0]  lookup_j_id,
  input  logic [3:0]  lookup_k_id,
  output logic        lookup_j_ready,
  output logic        lookup_k_ready,
  output logic [15:0] lookup_j_value,
  output logic [15:0] lookup_k_value,
  output logic        commit_reg_we,
  output logic [2:0]  commit_reg,
  output logic [15:0] commit_value,
  output logic        commit_cc_we,
  output logic [2:0]  commit_cc,
  output logic [3:0]  commit_id,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  output logic        empty,
  output logic        full
);

  localparam int DEPTH = 16;

  logic [3:0]  head_reg, head_next;
  logic [3:0]  tail_reg, tail_next;
  logic [4:0]  count_reg, count_next;

  logic [15:0] cdb_value;
  logic [3:0]  cdb_qdest;
  logic [2:0]  cdb_cc;

  logic        alloc_fire;
  logic        commit_fire;
  logic        head_eligible;
  logic        head_store;
  logic        reg_retire;

  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_modifies_cc;
  logic [DEPTH-1:0] entry_writes_reg;
  logic [DEPTH-1:0] entry_writes_mem;
  logic [15:0]      entry_value   [DEPTH];
  logic [15:0]      entry_address [DEPTH];
  logic [2:0]       entry_dest    [DEPTH];
  logic [2:0]       entry_cc      [DEPTH];
  logic [3:0]       entry_opcode  [DEPTH];

  logic [3:0]  lookup_id    [2];
  logic        lookup_ready [2];
  logic [15:0] lookup_value [2];

  logic        unused_bits;

  // CDB word layout: {data[15:0], qdest[3:0], cc[2:0], modifies_cc}
  assign cdb_value = cdb_data[23:8];
  assign cdb_qdest = cdb_data[7:4];
  assign cdb_cc    = cdb_data[3:1];

  assign empty       = (count_reg == 5'd0);
  assign full        = (count_reg == 5'd16);
  assign alloc_ready = !full;
  assign alloc_id    = tail_reg;
  assign alloc_fire  = alloc_valid && alloc_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [3:0] ID = 4'(gi);

      logic [3:0]  offset;
      logic        alloc_hit;
      logic        cdb_hit;
      logic        valid_reg;
      logic        cc_write_reg;
      logic        reg_write_reg;
      logic        mem_write_reg;
      logic [3:0]  opcode_reg;
      logic [2:0]  dest_reg;
      logic [2:0]  cc_reg;
      logic [15:0] address_reg;
      logic [15:0] value_reg;

      // Distance from head modulo 16 decides whether this slot is in flight
      assign offset       = ID - head_reg;
      assign occupied[gi] = full || ({1'b0, offset} < count_reg);
      assign alloc_hit    = alloc_fire && (tail_reg == ID);
      assign cdb_hit      = cdb_valid && occupied[gi] && (cdb_qdest == ID);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg     <= 1'b0;
          cc_write_reg  <= 1'b0;
          reg_write_reg <= 1'b0;
          mem_write_reg <= 1'b0;
          opcode_reg    <= 4'd0;
          dest_reg      <= 3'd0;
          cc_reg        <= 3'd0;
          address_reg   <= 16'd0;
          value_reg     <= 16'd0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (alloc_hit) begin
          valid_reg     <= alloc_done;
          cc_write_reg  <= alloc_modifies_cc;
          reg_write_reg <= alloc_writes_reg;
          mem_write_reg <= alloc_writes_mem;
          opcode_reg    <= alloc_opcode;
          dest_reg      <= alloc_dest_reg;
          cc_reg        <= 3'd0;
          address_reg   <= alloc_address;
          value_reg     <= alloc_value;
        end else if (cdb_hit) begin
          valid_reg <= 1'b1;
          cc_reg    <= cdb_cc;
          value_reg <= cdb_value;
        end
      end

      assign entry_valid[gi]       = valid_reg;
      assign entry_modifies_cc[gi] = cc_write_reg;
      assign entry_writes_reg[gi]  = reg_write_reg;
      assign entry_writes_mem[gi]  = mem_write_reg;
      assign entry_opcode[gi]      = opcode_reg;
      assign entry_dest[gi]        = dest_reg;
      assign entry_cc[gi]          = cc_reg;
      assign entry_address[gi]     = address_reg;
      assign entry_value[gi]       = value_reg;
    end
  endgenerate

  assign lookup_id[0]   = lookup_j_id;
  assign lookup_id[1]   = lookup_k_id;
  assign lookup_j_ready = lookup_ready[0];
  assign lookup_k_ready = lookup_ready[1];
  assign lookup_j_value = lookup_value[0];
  assign lookup_k_value = lookup_value[1];

  // A same-cycle CDB broadcast to the tagged entry is forwarded straight to dispatch
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lookup_ready[p] = 1'b0;
      lookup_value[p] = 16'd0;
      if (occupied[lookup_id[p]]) begin
        if (cdb_valid && (cdb_qdest == lookup_id[p])) begin
          lookup_ready[p] = 1'b1;
          lookup_value[p] = cdb_value;
        end else begin
          lookup_ready[p] = entry_valid[lookup_id[p]];
          lookup_value[p] = entry_value[lookup_id[p]];
        end
      end
    end
  end

  assign head_eligible = !empty && entry_valid[head_reg];
  assign head_store    = entry_writes_mem[head_reg];
  assign reg_retire    = head_eligible && !head_store;
  // A store holds the head until memory acknowledges it
  assign commit_fire   = head_eligible && (!head_store || mem_resp);

  assign commit_reg_we = reg_retire && entry_writes_reg[head_reg];
  assign commit_cc_we  = reg_retire && entry_modifies_cc[head_reg];
  assign commit_reg    = reg_retire ? entry_dest[head_reg]  : 3'd0;
  assign commit_value  = reg_retire ? entry_value[head_reg] : 16'd0;
  assign commit_cc     = reg_retire ? entry_cc[head_reg]    : 3'd0;
  assign commit_id     = head_eligible ? head_reg : 4'd0;

  assign mem_write     = head_eligible && head_store;
  assign mem_address   = mem_write ? entry_address[head_reg] : 16'd0;
  assign mem_wdata     = mem_write ? entry_value[head_reg]   : 16'd0;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (alloc_fire) begin
      tail_next = tail_reg + 4'd1;
    end
    if (commit_fire) begin
      head_next = head_reg + 4'd1;
    end
    case ({alloc_fire, commit_fire})
      2'b10:   count_next = count_reg + 5'd1;
      2'b01:   count_next = count_reg - 5'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= 4'd0;
      tail_reg  <= 4'd0;
      count_reg <= 5'd0;
    end else if (flush) begin
      head_reg  <= 4'd0;
      tail_reg  <= 4'd0;
      count_reg <= 5'd0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // The opcode is carried for debug visibility; the CDB modifies_cc bit is superseded by the alloc flag
  assign unused_bits = ^{cdb_data[0], entry_opcode[head_reg]};

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed + randomized scoreboard bench for reorder_buffer.
// A program-order queue model predicts retirements; a negedge monitor compares.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_id;
  logic [3:0]  alloc_opcode;
  logic [2:0]  alloc_dest_reg;
  logic [15:0] alloc_address;
  logic [15:0] alloc_value;
  logic        alloc_done;
  logic        alloc_modifies_cc;
  logic        alloc_writes_reg;
  logic        alloc_writes_mem;
  logic        cdb_valid;
  logic [23:0] cdb_data;
  logic [3:0]  lookup_j_id;
  logic [3:0]  lookup_k_id;
  logic        lookup_j_ready;
  logic        lookup_k_ready;
  logic [15:0] lookup_j_value;
  logic [15:0] lookup_k_value;
  logic        commit_reg_we;
  logic [2:0]  commit_reg;
  logic [15:0] commit_value;
  logic        commit_cc_we;
  logic [2:0]  commit_cc;
  logic [3:0]  commit_id;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic        empty;
  logic        full;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .alloc_opcode(alloc_opcode), .alloc_dest_reg(alloc_dest_reg),
    .alloc_address(alloc_address), .alloc_value(alloc_value), .alloc_done(alloc_done),
    .alloc_modifies_cc(alloc_modifies_cc), .alloc_writes_reg(alloc_writes_reg),
    .alloc_writes_mem(alloc_writes_mem),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data),
    .lookup_j_id(lookup_j_id), .lookup_k_id(lookup_k_id),
    .lookup_j_ready(lookup_j_ready), .lookup_k_ready(lookup_k_ready),
    .lookup_j_value(lookup_j_value), .lookup_k_value(lookup_k_value),
    .commit_reg_we(commit_reg_we), .commit_reg(commit_reg), .commit_value(commit_value),
    .commit_cc_we(commit_cc_we), .commit_cc(commit_cc), .commit_id(commit_id),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .empty(empty), .full(full)
  );

  typedef struct {
    logic [3:0]  id;
    logic [2:0]  dest;
    logic [15:0] value;
    logic [15:0] address;
    logic [2:0]  cc;
    logic        done;
    logic        mcc;
    logic        wreg;
    logic        wmem;
  } ent_t;

  typedef struct {
    logic        store;
    logic [3:0]  id;
    logic [2:0]  dest;
    logic [15:0] value;
    logic [15:0] address;
    logic [2:0]  cc;
    logic        mcc;
  } exp_t;

  ent_t rob[$];
  exp_t exp_q[$];
  int   next_id = 0;

  logic        exp_empty, exp_full, exp_mem_write;
  logic [3:0]  exp_alloc_id;
  logic        exp_jr, exp_kr;
  logic [15:0] exp_jv, exp_kv;
  logic        checking = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    rob.delete();
    next_id = 0;
  endtask

  task automatic lk(input logic [3:0] id, output logic r, output logic [15:0] v);
    r = 1'b0;
    v = 16'd0;
    foreach (rob[i]) begin
      if (rob[i].id == id) begin
        if (cdb_valid && (cdb_data[7:4] == id)) begin
          r = 1'b1;
          v = cdb_data[23:8];
        end else begin
          r = rob[i].done;
          v = rob[i].value;
        end
      end
    end
  endtask

  // Expectations for the current cycle, computed from model state and the inputs just driven
  task automatic predict();
    exp_t e;
    exp_empty     = (rob.size() == 0);
    exp_full      = (rob.size() == 16);
    exp_alloc_id  = 4'(next_id);
    lk(lookup_j_id, exp_jr, exp_jv);
    lk(lookup_k_id, exp_kr, exp_kv);
    exp_mem_write = (rob.size() > 0) && rob[0].done && rob[0].wmem;
    if ((rob.size() > 0) && rob[0].done && (!rob[0].wmem || mem_resp)) begin
      e.store   = rob[0].wmem;
      e.id      = rob[0].id;
      e.dest    = rob[0].dest;
      e.value   = rob[0].value;
      e.address = rob[0].address;
      e.cc      = rob[0].cc;
      e.mcc     = rob[0].mcc;
      exp_q.push_back(e);
    end
  endtask

  // Apply one clock edge to the model: flush, CDB writeback, in-order retire, allocate
  task automatic model_edge();
    int   sz0;
    bit   retire;
    ent_t n;
    if (!reset_n || flush) begin
      model_reset();
      return;
    end
    sz0    = rob.size();
    retire = (sz0 > 0) && rob[0].done && (!rob[0].wmem || mem_resp);
    if (cdb_valid) begin
      for (int i = 0; i < rob.size(); i++) begin
        if (rob[i].id == cdb_data[7:4]) begin
          n       = rob[i];
          n.value = cdb_data[23:8];
          n.cc    = cdb_data[3:1];
          n.done  = 1'b1;
          rob[i]  = n;
        end
      end
    end
    if (retire) void'(rob.pop_front());
    if (alloc_valid && (sz0 < 16)) begin
      n.id      = 4'(next_id);
      n.dest    = alloc_dest_reg;
      n.value   = alloc_value;
      n.address = alloc_address;
      n.cc      = 3'd0;
      n.done    = alloc_done;
      n.mcc     = alloc_modifies_cc;
      n.wreg    = alloc_writes_reg;
      n.wmem    = alloc_writes_mem;
      rob.push_back(n);
      next_id = (next_id + 1) % 16;
    end
  endtask

  task automatic clear_inputs();
    flush             = 1'b0;
    alloc_valid       = 1'b0;
    alloc_opcode      = 4'd0;
    alloc_dest_reg    = 3'd0;
    alloc_address     = 16'd0;
    alloc_value       = 16'd0;
    alloc_done        = 1'b0;
    alloc_modifies_cc = 1'b0;
    alloc_writes_reg  = 1'b0;
    alloc_writes_mem  = 1'b0;
    cdb_valid         = 1'b0;
    cdb_data          = 24'd0;
    mem_resp          = 1'b0;
    lookup_j_id       = 4'($urandom_range(0, 15));
    lookup_k_id       = 4'($urandom_range(0, 15));
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    model_edge();
    #1;
    clear_inputs();
  endtask

  task automatic set_alloc(input logic [2:0] dest, input logic [15:0] value, input logic done,
                           input logic wmem, input logic [15:0] addr);
    alloc_valid       = 1'b1;
    alloc_dest_reg    = dest;
    alloc_value       = value;
    alloc_done        = done;
    alloc_writes_mem  = wmem;
    alloc_writes_reg  = !wmem;
    alloc_modifies_cc = !wmem;
    alloc_address     = addr;
    alloc_opcode      = wmem ? 4'h3 : 4'h1;
  endtask

  task automatic set_cdb(input logic [3:0] id, input logic [15:0] data, input logic [2:0] cc);
    cdb_valid = 1'b1;
    cdb_data  = {data, id, cc, 1'b1};
  endtask

  // Monitor: status every cycle, and one scoreboard pop per observed retirement
  initial begin
    logic ev, exp_ev;
    exp_t e;
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("empty", 32'(empty), 32'(exp_empty));
        chk("full", 32'(full), 32'(exp_full));
        chk("alloc_ready", 32'(alloc_ready), 32'(!exp_full));
        chk("alloc_id", 32'(alloc_id), 32'(exp_alloc_id));
        chk("mem_write", 32'(mem_write), 32'(exp_mem_write));
        chk("lookup_j_ready", 32'(lookup_j_ready), 32'(exp_jr));
        chk("lookup_j_value", 32'(lookup_j_value), 32'(exp_jv));
        chk("lookup_k_ready", 32'(lookup_k_ready), 32'(exp_kr));
        chk("lookup_k_value", 32'(lookup_k_value), 32'(exp_kv));
        ev     = commit_reg_we || commit_cc_we || (mem_write && mem_resp);
        exp_ev = (exp_q.size() != 0);
        chk("commit_event", 32'(ev), 32'(exp_ev));
        if (exp_ev) begin
          e = exp_q.pop_front();
          if (ev) begin
            chk("commit_id", 32'(commit_id), 32'(e.id));
            if (e.store) begin
              chk("mem_address", 32'(mem_address), 32'(e.address));
              chk("mem_wdata", 32'(mem_wdata), 32'(e.value));
              chk("store_reg_we", 32'(commit_reg_we), 32'(1'b0));
              chk("store_cc_we", 32'(commit_cc_we), 32'(1'b0));
              $display("store id=%0d addr=%04h data=%04h", commit_id, mem_address, mem_wdata);
            end else begin
              chk("commit_reg_we", 32'(commit_reg_we), 32'(1'b1));
              chk("commit_reg", 32'(commit_reg), 32'(e.dest));
              chk("commit_value", 32'(commit_value), 32'(e.value));
              chk("commit_cc_we", 32'(commit_cc_we), 32'(e.mcc));
              if (e.mcc) chk("commit_cc", 32'(commit_cc), 32'(e.cc));
              $display("commit id=%0d r%0d=%04h cc_we=%0d cc=%0d", commit_id, commit_reg,
                       commit_value, commit_cc_we, commit_cc);
            end
          end
        end
      end
    end
  end

  initial begin
    int hi;
    logic [3:0] pick;
    clear_inputs();
    reset_n  = 1'b0;
    checking = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Three born-complete instructions retire in order
    set_alloc(3'd1, 16'h0011, 1'b1, 1'b0, 16'h0); step();
    set_alloc(3'd2, 16'h0022, 1'b1, 1'b0, 16'h0); step();
    set_alloc(3'd3, 16'h0033, 1'b1, 1'b0, 16'h0); step();
    repeat (3) step();
    chk("drained_empty", 32'(empty), 32'(1'b1));

    // Out-of-order completion: id 1 finishes first, id 0 gates both
    flush = 1'b1; step();
    set_alloc(3'd4, 16'h0000, 1'b0, 1'b0, 16'h0); step();
    set_alloc(3'd5, 16'h0000, 1'b0, 1'b0, 16'h0); step();
    set_cdb(4'd1, 16'hBEEF, 3'b100); step();
    step();
    set_cdb(4'd0, 16'h1234, 3'b001); step();
    repeat (3) step();

    // Fill to 16, overflow attempt, then commit while allocating
    flush = 1'b1; step();
    for (int i = 0; i < 16; i++) begin
      set_alloc(3'(i), 16'(i), 1'b0, 1'b0, 16'h0); step();
    end
    chk("full_after_16", 32'(full), 32'(1'b1));
    set_alloc(3'd7, 16'hDEAD, 1'b1, 1'b0, 16'h0); step();
    chk("ignored_17th_id", 32'(alloc_id), 32'(4'd0));
    set_cdb(4'd0, 16'hA000, 3'b010); step();
    set_cdb(4'd1, 16'hA001, 3'b010); set_alloc(3'd6, 16'h0066, 1'b0, 1'b0, 16'h0); step();
    set_alloc(3'd6, 16'h0067, 1'b0, 1'b0, 16'h0); step();
    chk("wrapped_alloc_id", 32'(alloc_id), 32'(4'd1));

    // Store with memory acknowledging on its fourth cycle
    flush = 1'b1; step();
    set_alloc(3'd0, 16'h00FF, 1'b1, 1'b1, 16'h4000); step();
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      hi += int'(mem_write);
      mem_resp = (i == 3);
      step();
    end
    chk("store_write_cycles", 32'(hi), 32'd4);
    chk("store_retired", 32'(empty), 32'(1'b1));

    // Same-cycle CDB forwarding on a lookup
    flush = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      set_alloc(3'd2, 16'h0000, 1'b0, 1'b0, 16'h0); step();
    end
    lookup_j_id = 4'd2;
    set_cdb(4'd2, 16'h5A5A, 3'b001);
    #1;
    chk("bypass_ready", 32'(lookup_j_ready), 32'(1'b1));
    chk("bypass_value", 32'(lookup_j_value), 32'h5A5A);
    step();

    // Flush with a pending store at the head
    flush = 1'b1; step();
    set_alloc(3'd0, 16'h0BAD, 1'b1, 1'b1, 16'h4400); step();
    for (int i = 0; i < 4; i++) begin
      set_alloc(3'(i), 16'h0000, 1'b0, 1'b0, 16'h0); step();
    end
    chk("pending_store", 32'(mem_write), 32'(1'b1));
    flush = 1'b1; step();
    chk("flush_empty", 32'(empty), 32'(1'b1));
    chk("flush_mem_write", 32'(mem_write), 32'(1'b0));
    chk("flush_alloc_id", 32'(alloc_id), 32'(4'd0));

    // Asynchronous reset in the middle of a cycle
    set_alloc(3'd0, 16'h0BAD, 1'b1, 1'b1, 16'h4400); step();
    for (int i = 0; i < 4; i++) begin
      set_alloc(3'(i), 16'h0000, 1'b0, 1'b0, 16'h0); step();
    end
    #1 reset_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'(1'b1));
    chk("rst_full", 32'(full), 32'(1'b0));
    chk("rst_alloc_id", 32'(alloc_id), 32'(4'd0));
    chk("rst_mem_write", 32'(mem_write), 32'(1'b0));
    chk("rst_commit_we", 32'(commit_reg_we), 32'(1'b0));
    reset_n = 1'b1;
    model_reset();
    step();

    // Randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        alloc_valid       = 1'b1;
        alloc_writes_mem  = ($urandom_range(0, 5) == 0);
        alloc_writes_reg  = alloc_writes_mem ? 1'($urandom_range(0, 1)) : 1'b1;
        alloc_modifies_cc = 1'($urandom_range(0, 1));
        alloc_done        = ($urandom_range(0, 2) == 0);
        alloc_dest_reg    = 3'($urandom_range(0, 7));
        alloc_value       = 16'($urandom);
        alloc_address     = 16'($urandom);
        alloc_opcode      = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1) == 1) begin
        if ((rob.size() > 0) && ($urandom_range(0, 3) != 0))
          pick = rob[$urandom_range(0, rob.size() - 1)].id;
        else
          pick = 4'($urandom_range(0, 15));
        set_cdb(pick, 16'($urandom), 3'($urandom_range(0, 7)));
        cdb_data[0] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) lookup_j_id = pick;
      end
      mem_resp = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 99) == 0);
      step();
    end

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
